// File: rtl/sram_arbiter_if.sv
// Bundle of the two requester ports (A: data read/write, B: fetch read-only)
// and the split-data SRAM bus driven by the arbiter.
interface sram_arbiter_if;
    // Port A
    logic        a_req;
    logic        a_we;
    logic [19:0] a_addr;
    logic [31:0] a_wdata;
    logic [3:0]  a_be;
    logic        a_ack;
    logic [31:0] a_rdata;
    // Port B
    logic        b_req;
    logic [19:0] b_addr;
    logic        b_ack;
    logic [31:0] b_rdata;
    // SRAM side, controls active-low
    logic [19:0] ram_addr;
    logic [3:0]  ram_be_n;
    logic        ram_ce_n;
    logic        ram_oe_n;
    logic        ram_we_n;
    logic [31:0] ram_dout;
    logic        ram_dout_en;
    logic [31:0] ram_din;

    // Arbiter side
    modport slave (
        input  a_req, a_we, a_addr, a_wdata, a_be,
        input  b_req, b_addr,
        input  ram_din,
        output a_ack, a_rdata, b_ack, b_rdata,
        output ram_addr, ram_be_n, ram_ce_n, ram_oe_n, ram_we_n,
        output ram_dout, ram_dout_en
    );

    // Requesters plus SRAM device side
    modport master (
        output a_req, a_we, a_addr, a_wdata, a_be,
        output b_req, b_addr,
        output ram_din,
        input  a_ack, a_rdata, b_ack, b_rdata,
        input  ram_addr, ram_be_n, ram_ce_n, ram_oe_n, ram_we_n,
        input  ram_dout, ram_dout_en
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter for an asynchronous SRAM. Port A reads or
// writes with byte enables, port B only reads. Every SRAM output is a
// register loaded from the next-state decode, so strobes are glitch-free
// and appear in the first cycle of the state they belong to.
module sram_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2   // strobe cycles per access, 1..15
) (
    input logic         clk,
    input logic         rst,
    sram_arbiter_if.slave bus
);

    typedef enum logic [2:0] {IDLE, RD, WR, WR_HOLD, DONE} state_t;

    state_t      state_q, state_nx;
    logic [3:0]  cnt_q, cnt_nx;
    logic        gnt_b_q, gnt_b_nx;     // current transaction belongs to B
    logic        last_b_q, last_b_nx;   // most recent grant went to B
    logic [19:0] addr_q, addr_nx;
    logic [31:0] wdata_q, wdata_nx;
    logic [3:0]  be_q, be_nx;
    logic        pick_b;

    logic [19:0] ram_addr_nx;
    logic [3:0]  ram_be_n_nx;
    logic        ram_ce_n_nx, ram_oe_n_nx, ram_we_n_nx, ram_dout_en_nx;
    logic [31:0] ram_dout_nx;
    logic        a_ack_nx, b_ack_nx;
    logic [31:0] a_rdata_nx, b_rdata_nx;

    // Next-state, request latching and registered-output decode
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned and no latch is inferred.
        state_nx       = state_q;
        cnt_nx         = cnt_q;
        gnt_b_nx       = gnt_b_q;
        last_b_nx      = last_b_q;
        addr_nx        = addr_q;
        wdata_nx       = wdata_q;
        be_nx          = be_q;
        pick_b         = 1'b0;
        a_rdata_nx     = bus.a_rdata;
        b_rdata_nx     = bus.b_rdata;
        ram_addr_nx    = bus.ram_addr;
        ram_dout_nx    = bus.ram_dout;
        ram_be_n_nx    = 4'hF;
        ram_ce_n_nx    = 1'b1;
        ram_oe_n_nx    = 1'b1;
        ram_we_n_nx    = 1'b1;
        ram_dout_en_nx = 1'b0;
        a_ack_nx       = 1'b0;
        b_ack_nx       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.a_req || bus.b_req) begin
                    // On a tie the port that did not win last time goes first
                    pick_b    = bus.b_req && (!bus.a_req || !last_b_q);
                    gnt_b_nx  = pick_b;
                    last_b_nx = pick_b;
                    addr_nx   = pick_b ? bus.b_addr : bus.a_addr;
                    wdata_nx  = bus.a_wdata;
                    be_nx     = pick_b ? 4'h0 : bus.a_be;
                    cnt_nx    = 4'(WAIT_CYCLES - 1);
                    state_nx  = (!pick_b && bus.a_we) ? WR : RD;
                end
            end
            RD: begin
                if (cnt_q == 4'd0) begin
                    if (gnt_b_q) b_rdata_nx = bus.ram_din;
                    else         a_rdata_nx = bus.ram_din;
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt_q - 4'd1;
                end
            end
            WR: begin
                if (cnt_q == 4'd0) state_nx = WR_HOLD;
                else               cnt_nx   = cnt_q - 4'd1;
            end
            WR_HOLD: state_nx = DONE;
            // Requests are deliberately ignored here so a held req is not re-served
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        // Outputs are decoded from the state being entered
        unique case (state_nx)
            RD: begin
                ram_addr_nx = addr_nx;
                ram_ce_n_nx = 1'b0;
                ram_oe_n_nx = 1'b0;
                ram_be_n_nx = 4'h0;
            end
            WR, WR_HOLD: begin
                ram_addr_nx    = addr_nx;
                ram_dout_nx    = wdata_nx;
                ram_ce_n_nx    = 1'b0;
                ram_we_n_nx    = (state_nx == WR_HOLD);
                ram_be_n_nx    = ~be_nx;
                ram_dout_en_nx = 1'b1;
            end
            DONE: begin
                a_ack_nx = !gnt_b_nx;
                b_ack_nx = gnt_b_nx;
            end
            default: ;
        endcase
    end

    // State and output registers; reset aborts any access immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= 4'd0;
            gnt_b_q         <= 1'b0;
            last_b_q        <= 1'b1;
            addr_q          <= '0;
            wdata_q         <= '0;
            be_q            <= '0;
            bus.ram_addr    <= '0;
            bus.ram_be_n    <= 4'hF;
            bus.ram_ce_n    <= 1'b1;
            bus.ram_oe_n    <= 1'b1;
            bus.ram_we_n    <= 1'b1;
            bus.ram_dout    <= '0;
            bus.ram_dout_en <= 1'b0;
            bus.a_ack       <= 1'b0;
            bus.b_ack       <= 1'b0;
            bus.a_rdata     <= '0;
            bus.b_rdata     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q         <= state_nx;
            cnt_q           <= cnt_nx;
            gnt_b_q         <= gnt_b_nx;
            last_b_q        <= last_b_nx;
            addr_q          <= addr_nx;
            wdata_q         <= wdata_nx;
            be_q            <= be_nx;
            bus.ram_addr    <= ram_addr_nx;
            bus.ram_be_n    <= ram_be_n_nx;
            bus.ram_ce_n    <= ram_ce_n_nx;
            bus.ram_oe_n    <= ram_oe_n_nx;
            bus.ram_we_n    <= ram_we_n_nx;
            bus.ram_dout    <= ram_dout_nx;
            bus.ram_dout_en <= ram_dout_en_nx;
            bus.a_ack       <= a_ack_nx;
            bus.b_ack       <= b_ack_nx;
            bus.a_rdata     <= a_rdata_nx;
            bus.b_rdata     <= b_rdata_nx;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural SRAM. Stimulus pushes
// the expected ack (port, cycle, read data) into a scoreboard; a monitor on
// the falling edge pops and compares whenever an ack appears.
module tb_sram_arbiter;
    localparam int W = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    sram_arbiter_if ifc ();

    sram_arbiter #(.WAIT_CYCLES(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    // Cycle counter: cycle n of a transaction issued at count k is seen at
    // the falling edge when cyc == k + n
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAM: combinational read, byte-masked write on each edge
    // that sees ce and we active
    logic [31:0] mem [0:255];
    assign ifc.ram_din = mem[ifc.ram_addr[7:0]];

    always @(posedge clk) begin
        if (!ifc.ram_ce_n && !ifc.ram_we_n) begin
            for (int i = 0; i < 4; i++)
                if (!ifc.ram_be_n[i])
                    mem[ifc.ram_addr[7:0]][i*8 +: 8] <= ifc.ram_dout[i*8 +: 8];
        end
    end

    typedef struct {
        bit          port_b;
        bit          rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_a_rd = '0;
    logic [31:0] exp_b_rd = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ack must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (ifc.a_ack || ifc.b_ack)) begin
            check("single_ack", {31'd0, ifc.a_ack && ifc.b_ack}, 32'd0);
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_ack: got a_ack=%b b_ack=%b expected none (cycle %0d)",
                         ifc.a_ack, ifc.b_ack, cyc);
            end else begin
                e = sb.pop_front();
                check("ack_port", {31'd0, ifc.b_ack}, {31'd0, e.port_b});
                check("ack_cycle", cyc, e.cyc);
                if (e.port_b) begin
                    check("b_rdata", ifc.b_rdata, e.data);
                    check("a_rdata_hold", ifc.a_rdata, exp_a_rd);
                    exp_b_rd = e.data;
                end else begin
                    if (e.rd) begin
                        check("a_rdata", ifc.a_rdata, e.data);
                        exp_a_rd = e.data;
                    end else begin
                        check("a_rdata_hold_wr", ifc.a_rdata, exp_a_rd);
                    end
                    check("b_rdata_hold", ifc.b_rdata, exp_b_rd);
                end
            end
        end
    end

    // Port A access with per-cycle strobe checks; entered and left at posedge+1
    task automatic a_access(input bit we, input logic [19:0] addr, input logic [31:0] data,
                            input logic [3:0] be, input logic [31:0] exp_rd);
        int last;
        last = we ? W + 2 : W + 1;
        ifc.a_req   = 1'b1;
        ifc.a_we    = we;
        ifc.a_addr  = addr;
        ifc.a_wdata = data;
        ifc.a_be    = be;
        sb.push_back('{port_b: 1'b0, rd: !we, data: exp_rd, cyc: cyc + last});
        for (int n = 1; n <= last; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (we && n <= W) begin
                check($sformatf("wr_we_n_c%0d", n), {31'd0, ifc.ram_we_n}, 32'd0);
                check($sformatf("wr_ce_n_c%0d", n), {31'd0, ifc.ram_ce_n}, 32'd0);
                check($sformatf("wr_be_n_c%0d", n), {28'd0, ifc.ram_be_n}, {28'd0, ~be});
                check($sformatf("wr_dout_c%0d", n), ifc.ram_dout, data);
                check($sformatf("wr_addr_c%0d", n), {12'd0, ifc.ram_addr}, {12'd0, addr});
                check($sformatf("wr_oe_en_c%0d", n), {30'd0, ifc.ram_oe_n, ifc.ram_dout_en}, 32'd3);
            end else if (we && n == W + 1) begin
                check("hold_we_n", {31'd0, ifc.ram_we_n}, 32'd1);
                check("hold_ce_n", {31'd0, ifc.ram_ce_n}, 32'd0);
                check("hold_be_n", {28'd0, ifc.ram_be_n}, {28'd0, ~be});
                check("hold_dout", ifc.ram_dout, data);
                check("hold_addr", {12'd0, ifc.ram_addr}, {12'd0, addr});
            end else if (!we && n <= W) begin
                check($sformatf("rd_strobes_c%0d", n),
                      {28'd0, ifc.ram_ce_n, ifc.ram_oe_n, ifc.ram_we_n, ifc.ram_dout_en}, 32'h2);
                check($sformatf("rd_be_n_c%0d", n), {28'd0, ifc.ram_be_n}, 32'd0);
                check($sformatf("rd_addr_c%0d", n), {12'd0, ifc.ram_addr}, {12'd0, addr});
            end else begin
                check("done_idle_bus",
                      {28'd0, ifc.ram_ce_n, ifc.ram_oe_n, ifc.ram_we_n, ifc.ram_dout_en}, 32'hE);
            end
        end
        @(posedge clk);
        #1 ifc.a_req = 1'b0;
    endtask

    initial begin
        int k;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        ifc.a_req = 1'b0; ifc.a_we = 1'b0; ifc.a_addr = '0; ifc.a_wdata = '0; ifc.a_be = '0;
        ifc.b_req = 1'b0; ifc.b_addr = '0;

        // Reset state
        #12;
        check("rst_ctrl", {28'd0, ifc.ram_ce_n, ifc.ram_oe_n, ifc.ram_we_n, ifc.ram_dout_en}, 32'hE);
        check("rst_be_n", {28'd0, ifc.ram_be_n}, 32'hF);
        check("rst_addr", {12'd0, ifc.ram_addr}, 32'd0);
        check("rst_dout", ifc.ram_dout, 32'd0);
        check("rst_acks", {30'd0, ifc.a_ack, ifc.b_ack}, 32'd0);
        check("rst_a_rdata", ifc.a_rdata, 32'd0);
        check("rst_b_rdata", ifc.b_rdata, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Full word write, then read it back
        a_access(1'b1, 20'h00010, 32'hDEADBEEF, 4'hF, 32'h0);
        a_access(1'b0, 20'h00010, 32'h0, 4'hF, 32'hDEADBEEF);
        // Single-byte write: only byte 1 lands in the SRAM
        a_access(1'b1, 20'h00020, 32'h1234AB78, 4'b0010, 32'h0);

        // Reset during WR: strobes drop at once, no ack
        ifc.a_req = 1'b1; ifc.a_we = 1'b1; ifc.a_addr = 20'h00030;
        ifc.a_wdata = 32'h55555555; ifc.a_be = 4'hF;
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_we_n", {31'd0, ifc.ram_we_n}, 32'd0);
        #2 rst = 1'b1;
        #1;
        check("abort_we_n", {31'd0, ifc.ram_we_n}, 32'd1);
        check("abort_dout_en", {31'd0, ifc.ram_dout_en}, 32'd0);
        check("abort_ce_n", {31'd0, ifc.ram_ce_n}, 32'd1);
        check("abort_a_ack", {31'd0, ifc.a_ack}, 32'd0);
        ifc.a_req = 1'b0;
        exp_a_rd = '0;
        exp_b_rd = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("post_rst_idle", {30'd0, ifc.ram_ce_n, ifc.a_ack}, 32'd2);
        end
        @(posedge clk);
        #1;

        // Both ports held: A (first tie after reset), then B, then A
        k = cyc;
        ifc.a_req = 1'b1; ifc.a_we = 1'b0; ifc.a_addr = 20'h00020;
        ifc.b_req = 1'b1; ifc.b_addr = 20'h00010;
        sb.push_back('{port_b: 1'b0, rd: 1'b1, data: 32'h0000AB00, cyc: k + 3});
        sb.push_back('{port_b: 1'b1, rd: 1'b1, data: 32'hDEADBEEF, cyc: k + 7});
        sb.push_back('{port_b: 1'b0, rd: 1'b1, data: 32'h0000AB00, cyc: k + 11});
        repeat (12) @(posedge clk);
        #1 ifc.a_req = 1'b0; ifc.b_req = 1'b0;

        // B drops its request in the first RD cycle: still acked once
        k = cyc;
        ifc.b_req = 1'b1; ifc.b_addr = 20'h00020;
        sb.push_back('{port_b: 1'b1, rd: 1'b1, data: 32'h0000AB00, cyc: k + 3});
        @(posedge clk);
        #1 ifc.b_req = 1'b0;
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            if (n <= W)
                check($sformatf("b_rd_c%0d", n), {27'd0, ifc.ram_ce_n, ifc.ram_be_n}, 32'd0);
            else if (n > W + 1)
                check($sformatf("b_no_restart_c%0d", n), {31'd0, ifc.ram_ce_n}, 32'd1);
        end

        // Every pushed expectation must have been consumed by now
        repeat (10) @(posedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
